dsp_simd_pack: RTL and testbench

//  Gathers a stream of scalar operand pairs (a,b) into one SIMD word of `lanes` lanes.

---
 rtl/dsp_pack_pkg.sv | 14 +
 rtl/dsp_pack_out_reg.sv | 41 ++++
 rtl/dsp_simd_pack.sv | 140 ++++++++++++++
 tb/tb_dsp_simd_pack.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pack_pkg.sv
// rtl/dsp_pack_pkg.sv - shared types and limits for the SIMD operand packer
package dsp_pack_pkg;

   localparam int DSP_SIMD_W = 48;
   localparam int MAX_LANES  = 4;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } gather_state_t;

   typedef logic [1:0] lane_idx_t;

endpackage

// File: rtl/dsp_pack_out_reg.sv
// rtl/dsp_pack_out_reg.sv - single-entry valid/ready holding register for packed words
module dsp_pack_out_reg
   import dsp_pack_pkg::*;
#(
   parameter int dw = DSP_SIMD_W,
   parameter int mw = MAX_LANES
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          load_valid,
   output logic          load_ready,
   input  logic [dw-1:0] load_a,
   input  logic [dw-1:0] load_b,
   input  logic [mw-1:0] load_mask,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [dw-1:0] out_a,
   output logic [dw-1:0] out_b,
   output logic [mw-1:0] out_mask
);

   // Accept a new word while empty or while the held word leaves this cycle.
   assign load_ready = !out_valid || out_ready;

   always_ff @(posedge clock) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_a     <= '0;
         out_b     <= '0;
         out_mask  <= '0;
      end else if (load_valid && load_ready) begin
         out_valid <= 1'b1;
         out_a     <= load_a;
         out_b     <= load_b;
         out_mask  <= load_mask;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/dsp_simd_pack.sv
// rtl/dsp_simd_pack.sv - gathers scalar (a,b) pairs into SIMD words; DSP_PACK_FLUSH_EN adds flush
module dsp_simd_pack
   import dsp_pack_pkg::*;
#(
   parameter int width = 12,
   parameter int lanes = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [width-1:0]       in_a,
   input  logic [width-1:0]       in_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [width*lanes-1:0] out_a,
   output logic [width*lanes-1:0] out_b,
   output logic [lanes-1:0]       out_mask
`ifdef DSP_PACK_FLUSH_EN
   ,
   input  logic                   flush
`endif
);

   localparam int W = width * lanes;

   gather_state_t  state, state_n;
   lane_idx_t      idx, idx_n;
   logic [W-1:0]   gather_a, gather_b, gather_a_n, gather_b_n;
   logic [lanes-1:0] gather_mask, gather_mask_n;

   logic           flush_req;
   logic           accept, complete, load_ready, word_valid;
   logic [W-1:0]   fill_a, fill_b, word_a, word_b;
   logic [lanes-1:0] fill_mask, word_mask;

`ifdef DSP_PACK_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   assign in_ready = (state == FILL);

   always_comb begin
      accept    = in_valid && in_ready;
      fill_a    = gather_a;
      fill_b    = gather_b;
      fill_mask = gather_mask;
      for (int i = 0; i < lanes; i++) begin
         if (accept && idx == lane_idx_t'(i)) begin
            fill_a[i*width +: width] = in_a;
            fill_b[i*width +: width] = in_b;
            fill_mask[i]             = 1'b1;
         end
      end
      // fill_mask already counts a same-cycle accept, so flush sees k correctly.
      complete = (state == FILL) &&
                 ((accept && idx == lane_idx_t'(lanes - 1)) ||
                  (flush_req && fill_mask != '0));
      word_valid = (state == FULL) || complete;
      word_a     = (state == FULL) ? gather_a    : fill_a;
      word_b     = (state == FULL) ? gather_b    : fill_b;
      word_mask  = (state == FULL) ? gather_mask : fill_mask;
   end

   always_comb begin
      state_n       = state;
      idx_n         = idx;
      gather_a_n    = gather_a;
      gather_b_n    = gather_b;
      gather_mask_n = gather_mask;
      case (state)
         FILL: begin
            if (complete) begin
               idx_n = '0;
               if (load_ready) begin
                  gather_a_n    = '0;
                  gather_b_n    = '0;
                  gather_mask_n = '0;
               end else begin
                  gather_a_n    = fill_a;
                  gather_b_n    = fill_b;
                  gather_mask_n = fill_mask;
                  state_n       = FULL;
               end
            end else if (accept) begin
               gather_a_n    = fill_a;
               gather_b_n    = fill_b;
               gather_mask_n = fill_mask;
               idx_n         = idx + 2'd1;
            end
         end
         FULL: begin
            if (load_ready) begin
               gather_a_n    = '0;
               gather_b_n    = '0;
               gather_mask_n = '0;
               state_n       = FILL;
            end
         end
         default: state_n = FILL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= FILL;
         idx         <= '0;
         gather_a    <= '0;
         gather_b    <= '0;
         gather_mask <= '0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         gather_a    <= gather_a_n;
         gather_b    <= gather_b_n;
         gather_mask <= gather_mask_n;
      end
   end

   dsp_pack_out_reg #(
      .dw (W),
      .mw (lanes)
   ) u_out_reg (
      .clock      (clock),
      .reset      (reset),
      .load_valid (word_valid),
      .load_ready (load_ready),
      .load_a     (word_a),
      .load_b     (word_b),
      .load_mask  (word_mask),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_a      (out_a),
      .out_b      (out_b),
      .out_mask   (out_mask)
   );

endmodule

// File: tb/tb_dsp_simd_pack.sv
// tb/tb_dsp_simd_pack.sv - scoreboard bench for dsp_simd_pack (DSP_PACK_FLUSH_EN adds flush tests)
module tb_dsp_simd_pack;

   localparam int WD = 12;
   localparam int LN = 4;
   localparam int W  = WD * LN;

   typedef struct packed {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [LN-1:0] mask;
   } word_t;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [WD-1:0] in_a, in_b;
   logic [W-1:0]  out_a, out_b;
   logic [LN-1:0] out_mask;
`ifdef DSP_PACK_FLUSH_EN
   logic          flush;
`endif

   int            n_checks = 0;
   int            n_fail   = 0;
   int            cycle    = 0;
   int            n_words  = 0;
   int            stalls   = 0;
   word_t         sb_q[$];
   int            xfer_cyc[$];
   logic [W-1:0]  m_a, m_b;
   logic [LN-1:0] m_mask;
   int            m_k;

   always #5 clock = ~clock;
   always @(posedge clock) cycle <= cycle + 1;

   dsp_simd_pack #(.width(WD), .lanes(LN)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_mask  (out_mask)
`ifdef DSP_PACK_FLUSH_EN
      ,
      .flush     (flush)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      m_a = '0; m_b = '0; m_mask = '0; m_k = 0;
   endtask

   task automatic model_emit();
      word_t w;
      w.a = m_a; w.b = m_b; w.mask = m_mask;
      sb_q.push_back(w);
      model_clear();
   endtask

   // Called at #1 after an edge; returns at #1 after the accepting edge.
   task automatic send(input logic [WD-1:0] a, input logic [WD-1:0] b);
      int guard = 0;
      in_a = a; in_b = b; in_valid = 1'b1;
      while (!in_ready && guard < 100) begin
         @(posedge clock); #1;
         guard++;
      end
      if (guard != 0) stalls++;
      if (guard >= 100) check("send_timeout", 64'(guard), 64'd0);
      @(posedge clock);
      m_a[m_k*WD +: WD] = a;
      m_b[m_k*WD +: WD] = b;
      m_mask[m_k] = 1'b1;
      m_k++;
      if (m_k == LN) model_emit();
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while (sb_q.size() != 0 && guard < 200) begin
         @(posedge clock); #1;
         guard++;
      end
      check("drain_timeout", 64'(sb_q.size()), 64'd0);
   endtask

   always @(negedge clock) begin
      if (reset && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_word", {16'd0, out_a}, 64'd0);
         end else begin
            word_t e;
            e = sb_q.pop_front();
            check("word_a", {16'd0, out_a}, {16'd0, e.a});
            check("word_b", {16'd0, out_b}, {16'd0, e.b});
            check("word_mask", 64'(out_mask), 64'(e.mask));
         end
         n_words++;
         xfer_cyc.push_back(cycle);
      end
   end

   initial begin
      word_t held;
      int    words0;
      reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
`ifdef DSP_PACK_FLUSH_EN
      flush = 1'b0;
`endif
      model_clear();

      // 1: reset
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_mask", 64'(out_mask), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // 2: basic word with sign bits
      send(12'd1, 12'd16);
      send(12'd2, 12'd7);
      send(12'd3, 12'd7);
      send(12'hFFF, 12'hFF9);
      check("t2_out_valid", 64'(out_valid), 64'd1);
      check("t2_out_a", {16'd0, out_a}, {16'd0, 48'hFFF_003_002_001});
      check("t2_out_b", {16'd0, out_b}, {16'd0, 48'hFF9_007_007_010});
      check("t2_out_mask", 64'(out_mask), 64'hF);
      drain();

      // 3: backpressure, gather fills behind a held word
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(WD'(12'h100 + i), WD'(12'h800 - i));
      check("t3_in_ready_full", 64'(in_ready), 64'd0);
      held = sb_q[0];
      repeat (3) @(posedge clock);
      #1;
      check("t3_hold_valid", 64'(out_valid), 64'd1);
      check("t3_hold_a", {16'd0, out_a}, {16'd0, held.a});
      check("t3_hold_mask", 64'(out_mask), 64'(held.mask));
      words0 = n_words;
      out_ready = 1'b1;
      drain();
      check("t3_two_words", 64'(n_words - words0), 64'd2);
      check("t3_in_ready_back", 64'(in_ready), 64'd1);

      // 4: full throughput
      xfer_cyc.delete();
      stalls = 0;
      for (int i = 0; i < 12; i++) send(WD'($urandom), WD'($urandom));
      drain();
      check("t4_stalls", 64'(stalls), 64'd0);
      check("t4_words", 64'(xfer_cyc.size()), 64'd3);
      if (xfer_cyc.size() == 3) begin
         check("t4_gap1", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'd4);
         check("t4_gap2", 64'(xfer_cyc[2] - xfer_cyc[1]), 64'd4);
      end

      // 5: reset discards a partial gather
      send(12'hAAA, 12'h555);
      send(12'hBBB, 12'h444);
      reset = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      model_clear();
      check("t5_out_valid", 64'(out_valid), 64'd0);
      words0 = n_words;
      for (int i = 0; i < 4; i++) send(WD'(12'h010 * (i + 1)), WD'(12'h0F0 - i));
      drain();
      check("t5_one_word", 64'(n_words - words0), 64'd1);

`ifdef DSP_PACK_FLUSH_EN
      // 6: flush emits a partial word; empty flush is a no-op
      send(12'd5, 12'd9);
      send(12'd6, 12'd8);
      flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      model_emit();
      check("t6_out_valid", 64'(out_valid), 64'd1);
      check("t6_out_a", {16'd0, out_a}, {16'd0, 48'h000_000_006_005});
      check("t6_out_mask", 64'(out_mask), 64'h3);
      drain();
      words0 = n_words;
      flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      check("t6_empty_flush", 64'(n_words - words0), 64'd0);
`endif

      repeat (2) @(posedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
